// File: rtl/shift_add_mulmod_pkg.sv
// Shared types for the shift-add multiplier.
// Holds the controller state encoding and the two operating-mode codes.
// There are no ports: the top module and the step cell import this package.
package rsa_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MOD = 1'b1;

endpackage

// File: rtl/shift_add_mulmod_if.sv
// Request/result bundle for shift_add_mulmod.
// master drives: start_i, mode_i, a_i, b_i, n_i
// slave drives:  ready_o, busy_o, done_o, err_o, prod_o (2*WIDTH bits)
interface shift_add_mulmod_if #(
    parameter int WIDTH = 8
);
    logic                   start_i;
    logic                   mode_i;
    logic [WIDTH-1:0]       a_i;
    logic [WIDTH-1:0]       b_i;
    logic [WIDTH-1:0]       n_i;
    logic                   ready_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    logic [2*WIDTH-1:0]     prod_o;

    modport master (
        output start_i, mode_i, a_i, b_i, n_i,
        input  ready_o, busy_o, done_o, err_o, prod_o
    );

    modport slave (
        input  start_i, mode_i, a_i, b_i, n_i,
        output ready_o, busy_o, done_o, err_o, prod_o
    );
endinterface

// File: rtl/shift_add_mulmod_step.sv
// One modular double-and-add step of the MSB-first interleaved multiplier.
// Ports: r (running remainder, < n), a (multiplicand, < n), n (modulus),
//        mbit (current multiplier bit), r_next ((2r + mbit*a) mod n).
// Because r < n and a < n, the sum is below 3n, so at most two conditional
// subtractions are needed to bring it back into range.
module mulmod_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    input  logic             mbit,
    output logic [WIDTH-1:0] r_next
);
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] t1;

    always_comb begin
        n_ext = {2'b00, n};
        t     = {1'b0, r, 1'b0} + (mbit ? {2'b00, a} : '0);
        t1    = (t >= n_ext) ? (t - n_ext) : t;
        // After the second subtraction the value is below n, so it fits WIDTH bits.
        r_next = (t1 >= n_ext) ? WIDTH'(t1 - n_ext) : t1[WIDTH-1:0];
    end
endmodule

// File: rtl/shift_add_mulmod.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Mode 0: plain product A*B (2W bits). Mode 1: A*B mod N (zero-extended).
// Ports: clk, rst_n (synchronous, active low),
//        bus (slave): start_i/mode_i/a_i/b_i/n_i in, ready_o/busy_o/done_o/err_o/prod_o out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a request; an accepted start latches the operands
// ST_RUN  | one multiplier bit processed per cycle, counter runs W..1
// ST_DONE | done_o pulse; prod_o/err_o hold this operation's result
module shift_add_mulmod
    import rsa_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_add_mulmod_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   hi_q;   // mode 0: upper product half; mode 1: remainder R
    logic [WIDTH-1:0]   lo_q;   // multiplier B, shifted right (mode 0) or left (mode 1)
    logic               mode_q;
    logic               err_q;
    logic [2*WIDTH-1:0] prod_q;

    logic               accept;
    logic               op_err;
    logic               last;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   mod_r;

    mulmod_step #(.WIDTH(WIDTH)) u_step (
        .r      (hi_q),
        .a      (a_q),
        .n      (n_q),
        .mbit   (lo_q[WIDTH-1]),
        .r_next (mod_r)
    );

    always_comb begin
        accept = bus.start_i && (state_q == ST_IDLE);
        op_err = (bus.mode_i == MODE_MOD) && ((bus.n_i == '0) || (bus.a_i >= bus.n_i));
        last   = (cnt_q == CNT_W'(1));
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = op_err ? ST_DONE : ST_RUN;
            ST_RUN:  if (last)   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            n_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mode_q  <= MODE_MUL;
            err_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= bus.a_i;
                n_q    <= bus.n_i;
                mode_q <= bus.mode_i;
                hi_q   <= '0;
                lo_q   <= bus.b_i;
                cnt_q  <= CNT_W'(WIDTH);
                err_q  <= op_err;
                if (op_err) prod_q <= '0;
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (mode_q == MODE_MUL) begin
                    hi_q <= sum[WIDTH:1];
                    lo_q <= {sum[0], lo_q[WIDTH-1:1]};
                    // Result is written on the final step so it is valid alongside done_o.
                    if (last) prod_q <= {sum, lo_q[WIDTH-1:1]};
                end else begin
                    hi_q <= mod_r;
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    if (last) prod_q <= {{WIDTH{1'b0}}, mod_r};
                end
            end
        end
    end

    always_comb begin
        bus.ready_o = (state_q == ST_IDLE);
        bus.busy_o  = (state_q == ST_RUN) || (state_q == ST_DONE);
        bus.done_o  = (state_q == ST_DONE);
        bus.err_o   = err_q;
        bus.prod_o  = prod_q;
    end
endmodule

// File: tb/tb_shift_add_mulmod.sv
module tb_shift_add_mulmod;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shift_add_mulmod_if #(.WIDTH(8))  if8 ();
    shift_add_mulmod_if #(.WIDTH(16)) if16 ();

    shift_add_mulmod #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    shift_add_mulmod #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    // Issue one request on the 8-bit unit; lat = cycles from accept edge to done_o.
    task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] n, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!if8.ready_o && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if8.start_i = 1'b1;
        if8.mode_i  = m;
        if8.a_i     = a;
        if8.b_i     = b;
        if8.n_i     = n;
        @(posedge clk);
        #1;
        if8.start_i = 1'b0;
        lat = 1;
        while (!if8.done_o && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic op16(input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] n, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!if16.ready_o && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if16.start_i = 1'b1;
        if16.mode_i  = m;
        if16.a_i     = a;
        if16.b_i     = b;
        if16.n_i     = n;
        @(posedge clk);
        #1;
        if16.start_i = 1'b0;
        lat = 1;
        while (!if16.done_o && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dcount;

        if8.start_i = 1'b0;  if8.mode_i = 1'b0;
        if8.a_i = '0;  if8.b_i = '0;  if8.n_i = '0;
        if16.start_i = 1'b0; if16.mode_i = 1'b0;
        if16.a_i = '0; if16.b_i = '0; if16.n_i = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(if8.ready_o), 64'd1);
        chk("rst_busy",  64'(if8.busy_o),  64'd0);
        chk("rst_done",  64'(if8.done_o),  64'd0);
        chk("rst_err",   64'(if8.err_o),   64'd0);
        chk("rst_prod",  64'(if8.prod_o),  64'd0);
        chk("rst_ready16", 64'(if16.ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 0 products
        op8(1'b0, 8'd13, 8'd11, 8'd0, lat);
        chk("m0_13x11_lat",  64'(lat), 64'd9);
        chk("m0_13x11_prod", 64'(if8.prod_o), 64'd143);
        chk("m0_13x11_err",  64'(if8.err_o), 64'd0);
        chk("m0_13x11_busy_done", 64'(if8.busy_o), 64'd1);
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(if8.done_o), 64'd0);
        chk("ready_after_done", 64'(if8.ready_o), 64'd1);
        chk("prod_held", 64'(if8.prod_o), 64'd143);

        op8(1'b0, 8'd255, 8'd255, 8'd0, lat);
        chk("m0_255x255_lat",  64'(lat), 64'd9);
        chk("m0_255x255_prod", 64'(if8.prod_o), 64'd65025);

        op8(1'b0, 8'd0, 8'd255, 8'd0, lat);
        chk("m0_0x255_prod", 64'(if8.prod_o), 64'd0);

        // Mode 1 modular products
        op8(1'b1, 8'd200, 8'd150, 8'd251, lat);
        chk("m1_200x150_lat",  64'(lat), 64'd9);
        chk("m1_200x150_prod", 64'(if8.prod_o), 64'd131);
        chk("m1_200x150_err",  64'(if8.err_o), 64'd0);

        op8(1'b1, 8'd250, 8'd250, 8'd251, lat);
        chk("m1_250x250_prod", 64'(if8.prod_o), 64'd1);

        // Operand errors: prior result is nonzero, so clearing to 0 is visible
        op8(1'b1, 8'd5, 8'd7, 8'd0, lat);
        chk("err_n0_lat",  64'(lat), 64'd1);
        chk("err_n0_err",  64'(if8.err_o), 64'd1);
        chk("err_n0_prod", 64'(if8.prod_o), 64'd0);

        op8(1'b0, 8'd13, 8'd11, 8'd0, lat);
        chk("pre_err_prod", 64'(if8.prod_o), 64'd143);
        op8(1'b1, 8'd20, 8'd3, 8'd17, lat);
        chk("err_a_ge_n_lat",  64'(lat), 64'd1);
        chk("err_a_ge_n_err",  64'(if8.err_o), 64'd1);
        chk("err_a_ge_n_prod", 64'(if8.prod_o), 64'd0);
        @(posedge clk);
        #1;
        chk("err_held", 64'(if8.err_o), 64'd1);

        // Start pulsed while running is ignored
        @(negedge clk);
        if8.start_i = 1'b1; if8.mode_i = 1'b0; if8.a_i = 8'd13; if8.b_i = 8'd11;
        @(posedge clk);
        #1;
        if8.start_i = 1'b0;
        chk("err_cleared_on_accept", 64'(if8.err_o), 64'd0);
        chk("run_ready", 64'(if8.ready_o), 64'd0);
        chk("run_busy",  64'(if8.busy_o),  64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        if8.start_i = 1'b1; if8.mode_i = 1'b1; if8.a_i = 8'd1; if8.b_i = 8'd1; if8.n_i = 8'd3;
        @(negedge clk);
        if8.start_i = 1'b0;
        lat = 0;
        while (!if8.done_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_ignore_done_seen", 64'(if8.done_o), 64'd1);
        chk("busy_ignore_prod", 64'(if8.prod_o), 64'd143);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (if8.done_o) dcount++;
        end
        chk("busy_no_queued_op", 64'(dcount), 64'd0);

        // Reset while running
        @(negedge clk);
        if8.start_i = 1'b1; if8.mode_i = 1'b0; if8.a_i = 8'd255; if8.b_i = 8'd255;
        @(posedge clk);
        #1;
        if8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", 64'(if8.ready_o), 64'd1);
        chk("midrst_busy",  64'(if8.busy_o),  64'd0);
        chk("midrst_prod",  64'(if8.prod_o),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (if8.done_o) dcount++;
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        op8(1'b1, 8'd200, 8'd150, 8'd251, lat);
        chk("post_rst_lat",  64'(lat), 64'd9);
        chk("post_rst_prod", 64'(if8.prod_o), 64'd131);

        // 16-bit instance
        op16(1'b0, 16'd65535, 16'd65535, 16'd0, lat);
        chk("w16_m0_lat",  64'(lat), 64'd17);
        chk("w16_m0_prod", 64'(if16.prod_o), 64'd4294836225);
        op16(1'b1, 16'd12345, 16'd54321, 16'd65521, lat);
        chk("w16_m1_lat",  64'(lat), 64'd17);
        chk("w16_m1_prod", 64'(if16.prod_o), 64'd50831);
        chk("w16_m1_err",  64'(if16.err_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
